// File: rtl/score_display.sv
// Four-digit multiplexed score display: per-frame snapshot of the scores,
// game-over winner banner that blinks.
module score_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] score1,
   input  logic [2:0] score2,
   input  logic       playing,
   input  logic       winner,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   localparam logic [6:0] SEG_P     = 7'b0011000;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [RW-1:0] rcnt;
   logic [BW-1:0] bcnt;
   logic          blink_on;
   logic [1:0]    idx;
   logic [2:0]    snap_s1;
   logic [2:0]    snap_s2;
   logic          snap_play;
   logic          snap_win;
   logic          r_wrap;
   logic          b_wrap;
   logic [3:0]    an_n;
   logic [6:0]    seg_n;

   function automatic logic [6:0] digit_code(input logic [2:0] v);
      logic [6:0] c;
      unique case (v)
         3'd0: c = 7'b0000001;
         3'd1: c = 7'b1001111;
         3'd2: c = 7'b0010010;
         3'd3: c = 7'b0000110;
         3'd4: c = 7'b1001100;
         3'd5: c = 7'b0100100;
         3'd6: c = 7'b0100000;
         3'd7: c = 7'b0001111;
      endcase
      return c;
   endfunction

   assign r_wrap = (rcnt == RW'(REFRESH_DIV - 1));
   assign b_wrap = (bcnt == BW'(BLINK_DIV - 1));
   assign dp     = 1'b1;

   always_comb begin
      seg_n = SEG_BLANK;
      an_n  = ~(4'b0001 << idx);
      unique case (idx)
         2'd3: seg_n = snap_play ? digit_code(snap_s1) : SEG_P;
         2'd2: seg_n = snap_play ? SEG_DASH
                     : digit_code(snap_win ? 3'd1 : 3'd2);
         2'd1: seg_n = snap_play ? SEG_DASH : SEG_BLANK;
         2'd0: seg_n = snap_play ? digit_code(snap_s2)
                     : digit_code(snap_win ? snap_s1 : snap_s2);
      endcase
      // Game-over blink hides the anodes only; segments keep scanning.
      if (!snap_play && !blink_on)
         an_n = 4'b1111;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt      <= '0;
         bcnt      <= '0;
         blink_on  <= 1'b1;
         idx       <= 2'd3;
         snap_s1   <= 3'd0;
         snap_s2   <= 3'd0;
         snap_play <= 1'b1;
         snap_win  <= 1'b0;
         an        <= 4'b1111;
         seg       <= SEG_BLANK;
      end else begin
         an  <= an_n;
         seg <= seg_n;
         rcnt <= r_wrap ? '0 : rcnt + 1'b1;
         if (r_wrap) begin
            idx <= idx - 2'd1;
            // Frame start: freeze the inputs for the whole next frame.
            if (idx == 2'd0) begin
               snap_s1   <= score1;
               snap_s2   <= score2;
               snap_play <= playing;
               snap_win  <= winner;
            end
         end
         bcnt <= b_wrap ? '0 : bcnt + 1'b1;
         if (b_wrap)
            blink_on <= ~blink_on;
      end
   end

endmodule
